// File: rtl/arb_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr_if
// Brief    : Request/grant bundle between requesters and the arb_rr arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface arb_rr_if #(
    parameter int N = 4
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    request;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;

    // Arbiter side drives the grant outputs.
    modport master (
        input  request,
        output grant,
        output grant_valid,
        output grant_id
    );

    // Requester side drives the request lines.
    modport slave (
        output request,
        input  grant,
        input  grant_valid,
        input  grant_id
    );
endinterface

`default_nettype wire

// File: rtl/arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr
// Brief    : Registered round-robin arbiter with zero-bubble handover.
//            Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD held edges.
// Revision : 1.0 - initial release
// ============================================================================
module arb_rr #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  wire logic  clk,
    input  wire logic  rst,
    arb_rr_if.master   bus
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            valid_q, valid_d;
    logic [ID_W-1:0] id_q,    id_d;
    logic [ID_W-1:0] ptr_q,   ptr_d;

    logic            take;
    logic            go_idle;
    logic [ID_W-1:0] new_id;
    logic [ID_W:0]   from_ptr;
    logic [ID_W:0]   from_owner;

    // Returns {found, index} of the first set bit at or after start, wrapping.
    function automatic logic [ID_W:0] f_search(input logic [N-1:0] req, input int start);
        logic [ID_W:0] r;
        int            idx;
        r = '0;
        for (int j = N - 1; j >= 0; j--) begin
            idx = start + j;
            if (idx >= N) idx = idx - N;
            if (req[idx]) r = {1'b1, idx[ID_W-1:0]};
        end
        return r;
    endfunction

    assign from_ptr   = f_search(bus.request, int'(ptr_q));
    assign from_owner = f_search(bus.request, int'(id_q) + 1);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD > 0);
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        take    = 1'b0;
        go_idle = 1'b0;
        new_id  = '0;
`ifdef ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (from_ptr[ID_W]) begin
                    take   = 1'b1;
                    new_id = from_ptr[ID_W-1:0];
                end
            end
            OWNED: begin
                if (!bus.request[id_q]) begin
                    if (from_owner[ID_W]) begin
                        take   = 1'b1;
                        new_id = from_owner[ID_W-1:0];
                    end else begin
                        go_idle = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                // Forced rotation only when someone else is waiting; otherwise saturate.
                else if ((hold_q == 8'(MAX_HOLD)) && |(bus.request & ~grant_q)) begin
                    take   = 1'b1;
                    new_id = from_owner[ID_W-1:0];
                end else if (hold_q != 8'(MAX_HOLD)) begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: go_idle = 1'b1;
        endcase

        if (take) begin
            state_d = OWNED;
            grant_d = {{(N-1){1'b0}}, 1'b1} << new_id;
            valid_d = 1'b1;
            id_d    = new_id;
            ptr_d   = (new_id == ID_W'(N - 1)) ? '0 : new_id + 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
        end else if (go_idle) begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            id_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hold_q <= '0;
        else      hold_q <= hold_d;
    end
`endif

    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;
    assign bus.grant_id    = id_q;

endmodule

`default_nettype wire
